// File: rtl/mesh_traffic_sequencer.sv
// Mesh traffic sequencer: broadcasts loader commands, starts a run, waits for idle, dumps PMUs.
// Optional watchdog on the WAIT state is compiled in with SEQ_TIMEOUT_EN.
module mesh_traffic_sequencer #(
   parameter int unsigned N_NODES        = 16,
   parameter int unsigned PMU_REGS       = 8,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   input  logic                     cmd_valid_i,
   output logic                     cmd_ready_o,
   input  logic [3:0]               cmd_node_i,
   input  logic [4:0]               cmd_id_i,
   input  logic                     cmd_write_i,
   input  logic [7:0]               cmd_axlen_i,
   input  logic                     cmd_resp_wait_i,
   input  logic                     run_i,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     timeout_o,
   output logic [N_NODES-1:0]       fifo_push_o,
   output logic [4:0]               id_o,
   output logic                     write_o,
   output logic [7:0]               axlen_o,
   output logic                     resp_wait_o,
   output logic                     start_o,
   input  logic [N_NODES-1:0]       idle_i,
   output logic [4:0]               pmu_addr_o,
   input  logic [N_NODES-1:0][31:0] pmu_data_i,
   output logic                     rd_valid_o,
   input  logic                     rd_ready_i,
   output logic [31:0]              rd_data_o,
   output logic [3:0]               rd_node_o,
   output logic [4:0]               rd_reg_o
);

   typedef enum logic [2:0] {
      StIdle, StStart, StWait, StDumpAddr, StDumpOut, StDone
   } state_e;

   localparam logic [3:0] LastNode = 4'(N_NODES - 1);
   localparam logic [4:0] LastReg  = 5'(PMU_REGS - 1);

   state_e              state_q, state_d;
   logic                ready_q;
   logic                cmd_hs;
   logic [N_NODES-1:0]  push_q, push_d;
   logic [3:0]          node_q, node_d;
   logic [4:0]          reg_q, reg_d;
   logic [1:0]          blank_q, blank_d;
   logic [4:0]          pmu_addr_q;
   logic [31:0]         data_q;
   logic                last_word;
   logic                forced;

   assign cmd_hs    = cmd_valid_i && ready_q;
   assign last_word = (node_q == LastNode) && (reg_q == LastReg);

   always_comb begin
      state_d = state_q;
      node_d  = node_q;
      reg_d   = reg_q;
      blank_d = blank_q;
      push_d  = '0;
      if (cmd_hs && (32'(cmd_node_i) < N_NODES)) begin
         push_d[cmd_node_i] = 1'b1;
      end
      unique case (state_q)
         StIdle: begin
            if (run_i && !cmd_hs) state_d = StStart;
         end
         StStart: begin
            node_d  = '0;
            reg_d   = '0;
            blank_d = '0;
            state_d = StWait;
         end
         StWait: begin
            if (blank_q != 2'd2) blank_d = blank_q + 2'd1;
            // idle_i is not trusted until the loaders have seen start_o
            if (forced || ((blank_q == 2'd2) && (&idle_i))) state_d = StDumpAddr;
         end
         StDumpAddr: state_d = StDumpOut;
         StDumpOut: begin
            if (rd_ready_i) begin
               if (last_word) begin
                  state_d = StDone;
               end else begin
                  state_d = StDumpAddr;
                  if (reg_q == LastReg) begin
                     reg_d  = '0;
                     node_d = node_q + 4'd1;
                  end else begin
                     reg_d = reg_q + 5'd1;
                  end
               end
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q     <= StIdle;
         ready_q     <= 1'b0;
         push_q      <= '0;
         node_q      <= '0;
         reg_q       <= '0;
         blank_q     <= '0;
         pmu_addr_q  <= '0;
         data_q      <= '0;
         id_o        <= '0;
         write_o     <= 1'b0;
         axlen_o     <= '0;
         resp_wait_o <= 1'b0;
      end else begin
         state_q <= state_d;
         ready_q <= (state_d == StIdle);
         push_q  <= push_d;
         node_q  <= node_d;
         reg_q   <= reg_d;
         blank_q <= blank_d;
         if (state_d == StDumpAddr) pmu_addr_q <= reg_d;
         if (state_q == StDumpAddr) data_q <= pmu_data_i[node_q];
         if (cmd_hs) begin
            id_o        <= cmd_id_i;
            write_o     <= cmd_write_i;
            axlen_o     <= cmd_axlen_i;
            resp_wait_o <= cmd_resp_wait_i;
         end
      end
   end

`ifdef SEQ_TIMEOUT_EN
   logic [31:0] wd_q;
   logic        timeout_q;

   assign forced    = (state_q == StWait) && (wd_q == 32'(TIMEOUT_CYCLES - 1));
   assign timeout_o = timeout_q;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wd_q      <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (state_q == StStart)     wd_q <= '0;
         else if (state_q == StWait) wd_q <= wd_q + 32'd1;
         if (state_d == StStart) timeout_q <= 1'b0;
         else if (forced)        timeout_q <= 1'b1;
      end
   end
`else
   assign forced    = 1'b0;
   assign timeout_o = 1'b0;
`endif

   assign cmd_ready_o = ready_q;
   assign busy_o      = (state_q != StIdle);
   assign start_o     = (state_q == StStart);
   assign done_o      = (state_q == StDone);
   assign rd_valid_o  = (state_q == StDumpOut);
   assign fifo_push_o = push_q;
   assign pmu_addr_o  = pmu_addr_q;
   assign rd_data_o   = data_q;
   assign rd_node_o   = node_q;
   assign rd_reg_o    = reg_q;

endmodule

// File: tb/tb_mesh_traffic_sequencer.sv
// Directed bench for mesh_traffic_sequencer; dump words are checked against a queue scoreboard.
module tb_mesh_traffic_sequencer;

   localparam int N  = 16;
   localparam int R  = 8;
   localparam int TO = 20;

   logic                aclk = 1'b0;
   logic                aresetn;
   logic                cmd_valid_i, cmd_ready_o;
   logic [3:0]          cmd_node_i;
   logic [4:0]          cmd_id_i;
   logic                cmd_write_i;
   logic [7:0]          cmd_axlen_i;
   logic                cmd_resp_wait_i;
   logic                run_i, busy_o, done_o, timeout_o;
   logic [N-1:0]        fifo_push_o;
   logic [4:0]          id_o;
   logic                write_o;
   logic [7:0]          axlen_o;
   logic                resp_wait_o, start_o;
   logic [N-1:0]        idle_i;
   logic [4:0]          pmu_addr_o;
   logic [N-1:0][31:0]  pmu_data_i;
   logic                rd_valid_o, rd_ready_i;
   logic [31:0]         rd_data_o;
   logic [3:0]          rd_node_o;
   logic [4:0]          rd_reg_o;

   mesh_traffic_sequencer #(.N_NODES(N), .PMU_REGS(R), .TIMEOUT_CYCLES(TO)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_node_i(cmd_node_i),
      .cmd_id_i(cmd_id_i), .cmd_write_i(cmd_write_i), .cmd_axlen_i(cmd_axlen_i),
      .cmd_resp_wait_i(cmd_resp_wait_i), .run_i(run_i), .busy_o(busy_o), .done_o(done_o),
      .timeout_o(timeout_o), .fifo_push_o(fifo_push_o), .id_o(id_o), .write_o(write_o),
      .axlen_o(axlen_o), .resp_wait_o(resp_wait_o), .start_o(start_o), .idle_i(idle_i),
      .pmu_addr_o(pmu_addr_o), .pmu_data_i(pmu_data_i), .rd_valid_o(rd_valid_o),
      .rd_ready_i(rd_ready_i), .rd_data_o(rd_data_o), .rd_node_o(rd_node_o),
      .rd_reg_o(rd_reg_o)
   );

   always #5 aclk = ~aclk;

   typedef struct packed {
      logic [3:0]  node;
      logic [4:0]  rg;
      logic [31:0] data;
   } word_t;

   word_t sb[$];
   int    tests = 0;
   int    fails = 0;

   function automatic logic [31:0] pmu_val(input int n, input logic [4:0] a);
      logic [7:0]  hi;
      logic [15:0] lo;
      hi = 8'(8'hC0 + n);
      lo = 16'(n * 97 + int'(a) * 13 + 1);
      return {hi, 3'b000, a, lo};
   endfunction

   // PMU register files respond combinationally to the broadcast address
   always_comb begin
      for (int n = 0; n < N; n++) pmu_data_i[n] = pmu_val(n, pmu_addr_o);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic expect_dump();
      for (int n = 0; n < N; n++)
         for (int r = 0; r < R; r++)
            sb.push_back({4'(n), 5'(r), pmu_val(n, 5'(r))});
   endtask

   // Consume the dump; latency counts ticks from the call to the first rd_valid_o.
   task automatic drain(input int stall_at, input logic exp_to, output int latency);
      int  idx = 0, stall = 0, dones = 0, starts = 0, pushes = 0;
      bit  fin = 0;
      latency    = -1;
      rd_ready_i = 1'b1;
      for (int t = 0; t < 3000 && !fin; t++) begin
         tick();
         if (start_o) starts++;
         if (fifo_push_o != '0) pushes++;
         if (rd_valid_o) begin
            if (latency < 0) latency = t + 1;
            if (sb.size() == 0) begin
               check("extra_word", 32'(rd_valid_o), 32'd0);
            end else begin
               check("rd_node", 32'(rd_node_o), 32'(sb[0].node));
               check("rd_reg", 32'(rd_reg_o), 32'(sb[0].rg));
               check("rd_data", rd_data_o, sb[0].data);
               check("timeout_in_dump", 32'(timeout_o), 32'(exp_to));
               if (idx == stall_at && stall < 10) begin
                  rd_ready_i = 1'b0;
                  stall++;
               end else begin
                  rd_ready_i = 1'b1;
                  void'(sb.pop_front());
                  idx++;
               end
            end
         end
         if (done_o) begin
            dones++;
            check("timeout_at_done", 32'(timeout_o), 32'(exp_to));
            fin = 1;
         end
      end
      rd_ready_i = 1'b1;
      check("done_seen", 32'(dones), 32'd1);
      check("words_left", 32'(sb.size()), 32'd0);
      check("words_taken", 32'(idx), 32'(N * R));
      check("start_during_dump", 32'(starts), 32'd0);
      check("push_during_run", 32'(pushes), 32'd0);
      if (stall_at >= 0) check("stall_cycles", 32'(stall), 32'd10);
      tick();
      check("done_one_cycle", 32'(done_o), 32'd0);
      check("idle_after_done", 32'(busy_o), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      int lat;
      int act;
      aresetn = 1'b0;
      cmd_valid_i = 1'b0; cmd_node_i = '0; cmd_id_i = '0; cmd_write_i = 1'b0;
      cmd_axlen_i = '0; cmd_resp_wait_i = 1'b0; run_i = 1'b0;
      idle_i = '1; rd_ready_i = 1'b1;

      repeat (3) tick();
      check("rst_ready", 32'(cmd_ready_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_push", 32'(fifo_push_o), 32'd0);
      check("rst_start", 32'(start_o), 32'd0);
      check("rst_done", 32'(done_o), 32'd0);
      check("rst_valid", 32'(rd_valid_o), 32'd0);
      check("rst_timeout", 32'(timeout_o), 32'd0);
      check("rst_axlen", 32'(axlen_o), 32'd0);

      aresetn = 1'b1;
      tick();
      check("ready_after_release", 32'(cmd_ready_o), 32'd1);

      // Back-to-back commands
      cmd_valid_i = 1'b1; cmd_node_i = 4'd3; cmd_id_i = 5'd5; cmd_write_i = 1'b1;
      cmd_axlen_i = 8'd7; cmd_resp_wait_i = 1'b1;
      tick();
      check("push_node3", 32'(fifo_push_o), 32'h0008);
      check("id_5", 32'(id_o), 32'd5);
      check("write_1", 32'(write_o), 32'd1);
      check("axlen_7", 32'(axlen_o), 32'd7);
      check("resp_wait_1", 32'(resp_wait_o), 32'd1);
      cmd_node_i = 4'd15; cmd_id_i = 5'd31; cmd_write_i = 1'b0;
      cmd_axlen_i = 8'hA5; cmd_resp_wait_i = 1'b0;
      tick();
      check("push_node15", 32'(fifo_push_o), 32'h8000);
      check("id_31", 32'(id_o), 32'd31);
      check("write_0", 32'(write_o), 32'd0);
      check("axlen_a5", 32'(axlen_o), 32'hA5);
      cmd_valid_i = 1'b0;
      tick();
      check("push_clear", 32'(fifo_push_o), 32'd0);
      check("id_hold", 32'(id_o), 32'd31);

      // Command has priority over run
      cmd_valid_i = 1'b1; cmd_node_i = 4'd9; cmd_id_i = 5'd2; run_i = 1'b1;
      tick();
      cmd_valid_i = 1'b0; run_i = 1'b0;
      check("prio_push", 32'(fifo_push_o), 32'h0200);
      check("prio_busy", 32'(busy_o), 32'd0);
      check("prio_start", 32'(start_o), 32'd0);
      tick();
      check("prio_still_idle", 32'(busy_o), 32'd0);

      // Full run with all loaders idle and a 10-cycle stall on word 37
      run_i = 1'b1;
      tick();
      run_i = 1'b0;
      check("run_start", 32'(start_o), 32'd1);
      check("run_busy", 32'(busy_o), 32'd1);
      check("run_not_ready", 32'(cmd_ready_o), 32'd0);
      expect_dump();
      cmd_valid_i = 1'b1; cmd_node_i = 4'd1;
      tick();
      cmd_valid_i = 1'b0;
      check("start_one_cycle", 32'(start_o), 32'd0);
      check("cmd_ignored", 32'(fifo_push_o), 32'd0);
      drain(37, 1'b0, lat);
      check("first_word_latency", 32'(lat), 32'd4);
      check("pmu_addr_hold", 32'(pmu_addr_o), 32'(R - 1));
      check("ready_after_run", 32'(cmd_ready_o), 32'd1);

`ifdef SEQ_TIMEOUT_EN
      // Node 5 never idles: the watchdog forces the dump
      idle_i[5] = 1'b0;
      run_i = 1'b1;
      tick();
      run_i = 1'b0;
      check("to_start", 32'(start_o), 32'd1);
      expect_dump();
      drain(-1, 1'b1, lat);
      check("to_latency", 32'(lat), 32'(TO + 2));
      check("to_sticky", 32'(timeout_o), 32'd1);
      idle_i = '1;
`endif

      // Reset pulse in WAIT abandons the run
      idle_i[5] = 1'b0;
      run_i = 1'b1;
      tick();
      run_i = 1'b0;
      check("rw_start", 32'(start_o), 32'd1);
      check("rw_timeout_cleared", 32'(timeout_o), 32'd0);
      act = 0;
`ifdef SEQ_TIMEOUT_EN
      repeat (8) begin
`else
      repeat (40) begin
`endif
         tick();
         if (rd_valid_o || timeout_o || !busy_o) act++;
      end
      check("wait_holds", 32'(act), 32'd0);
      aresetn = 1'b0;
      #2;
      check("arst_busy", 32'(busy_o), 32'd0);
      check("arst_ready", 32'(cmd_ready_o), 32'd0);
      check("arst_pmu_addr", 32'(pmu_addr_o), 32'd0);
      check("arst_rd_data", rd_data_o, 32'd0);
      check("arst_id", 32'(id_o), 32'd0);
      check("arst_timeout", 32'(timeout_o), 32'd0);
      tick();
      aresetn = 1'b1;
      idle_i = '1;
      tick();
      check("rw_ready", 32'(cmd_ready_o), 32'd1);
      act = 0;
      repeat (10) begin
         tick();
         if (start_o || rd_valid_o || done_o || busy_o || (fifo_push_o != '0)) act++;
      end
      check("rw_no_activity", 32'(act), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
